// File: rtl/mastermind_scorer_if.sv
// Mastermind scorer request/result bundle.
//   start   - one-cycle request to score
//   secret  - secret code, peg i in bits [3i+2:3i]
//   guess   - player guess, same packing as secret
//   exact   - right colour, right position count (0..4)
//   partial - right colour, wrong position count (0..4)
//   win     - last result had exact == 4
//   busy    - scoring pass in progress
//   done    - one-cycle pulse when a new result is on the outputs
interface mastermind_scorer_if;
    logic        start;
    logic [11:0] secret;
    logic [11:0] guess;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic        win;
    logic        busy;
    logic        done;

    // Requester side
    modport master (
        output start, secret, guess,
        input  exact, partial, win, busy, done
    );

    // Scorer side
    modport slave (
        input  start, secret, guess,
        output exact, partial, win, busy, done
    );
endinterface

// File: rtl/mastermind_scorer.sv
// Fixed-latency Mastermind guess scorer.
// A start in IDLE latches both codes; one EXACT cycle builds the position
// match mask, then eight COLOR cycles accumulate min(secret, guess) counts of
// each colour over the unmatched pegs. Results load on entry to DONE, which
// pulses done for one cycle.
// Ports:
//   clk   - system clock, rising edge
//   Reset - asynchronous, active-high reset
//   bus   - request/result bundle (slave side)
module mastermind_scorer (
    input  logic                       clk,
    input  logic                       Reset,
    mastermind_scorer_if.slave         bus
);

    localparam int unsigned PEGS    = 4;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned CODE_W  = PEGS * COL_W;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        COLOR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   secret_q;
    logic [CODE_W-1:0]   guess_q;
    logic [PEGS-1:0]     mask_q;
    logic [CNT_W-1:0]    exact_cnt_q;
    logic [CNT_W-1:0]    acc_q;
    logic [COL_W-1:0]    col_q;

    logic [CNT_W-1:0]    exact_r;
    logic [CNT_W-1:0]    partial_r;
    logic                win_r;
    logic                busy_r;
    logic                done_r;

    logic [PEGS-1:0]     match_c;
    logic [CNT_W-1:0]    match_cnt_c;
    logic [CNT_W-1:0]    sc_c;
    logic [CNT_W-1:0]    gc_c;
    logic [CNT_W-1:0]    acc_next_c;

    // Number of pegs of colour col among positions not already matched.
    function automatic logic [CNT_W-1:0] count_colour(
        input logic [CODE_W-1:0] code,
        input logic [PEGS-1:0]   mask,
        input logic [COL_W-1:0]  col
    );
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(PEGS); i++) begin
            if (!mask[i] && (code[COL_W*i +: COL_W] == col)) begin
                n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    // Per-position exact comparison and its popcount.
    always_comb begin
        match_c     = '0;
        match_cnt_c = '0;
        for (int i = 0; i < int'(PEGS); i++) begin
            match_c[i] = (secret_q[COL_W*i +: COL_W] == guess_q[COL_W*i +: COL_W]);
            match_cnt_c = match_cnt_c + CNT_W'(match_c[i]);
        end
    end

    // Colour-only contribution of the current colour index.
    always_comb begin
        sc_c       = count_colour(secret_q, mask_q, col_q);
        gc_c       = count_colour(guess_q,  mask_q, col_q);
        acc_next_c = acc_q + ((sc_c < gc_c) ? sc_c : gc_c);
    end

    // Scoring FSM with registered results and status.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            secret_q    <= '0;
            guess_q     <= '0;
            mask_q      <= '0;
            exact_cnt_q <= '0;
            acc_q       <= '0;
            col_q       <= '0;
            exact_r     <= '0;
            partial_r   <= '0;
            win_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        secret_q <= bus.secret;
                        guess_q  <= bus.guess;
                        busy_r   <= 1'b1;
                        state    <= EXACT;
                    end
                end
                EXACT: begin
                    mask_q      <= match_c;
                    exact_cnt_q <= match_cnt_c;
                    acc_q       <= '0;
                    col_q       <= '0;
                    state       <= COLOR;
                end
                COLOR: begin
                    acc_q <= acc_next_c;
                    col_q <= col_q + COL_W'(1);
                    // Last colour: publish all three results together.
                    if (col_q == COL_W'(7)) begin
                        exact_r   <= exact_cnt_q;
                        partial_r <= acc_next_c;
                        win_r     <= (exact_cnt_q == CNT_W'(PEGS));
                        done_r    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.exact   = exact_r;
    assign bus.partial = partial_r;
    assign bus.win     = win_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed testbench for mastermind_scorer.
module tb_mastermind_scorer;

    logic clk;
    logic Reset;
    int   checks;
    int   errors;

    mastermind_scorer_if bus ();

    mastermind_scorer dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Peg 0 is the least significant field.
    function automatic logic [11:0] pk(input logic [2:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    // Pulse start for one cycle and wait (bounded) for done; returns in IDLE.
    task automatic run_pass(input logic [11:0] s, input logic [11:0] g, output int lat);
        bus.secret = s;
        bus.guess  = g;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        if (lat >= 0) @(negedge clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.start = 1'b0;
        bus.secret = '0;
        bus.guess = '0;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.exact !== 3'd0) begin errors++; $display("FAIL reset_exact got %0d expected 0", bus.exact); end
        checks++; if (bus.partial !== 3'd0) begin errors++; $display("FAIL reset_partial got %0d expected 0", bus.partial); end
        checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL reset_win got %0b expected 0", bus.win); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b expected 0", bus.done); end
    endtask

    task automatic test_identical();
        int lat;
        int busy_cnt;
        bus.secret = pk(3'd3, 3'd1, 3'd4, 3'd5);
        bus.guess  = pk(3'd3, 3'd1, 3'd4, 3'd5);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int i = 0; i <= 40; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done && lat < 0) lat = i;
            if (!bus.busy) break;
            @(negedge clk);
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL identical_latency got %0d expected 9", lat); end
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL identical_busy_cycles got %0d expected 10", busy_cnt); end
        checks++; if (bus.exact !== 3'd4) begin errors++; $display("FAIL identical_exact got %0d expected 4", bus.exact); end
        checks++; if (bus.partial !== 3'd0) begin errors++; $display("FAIL identical_partial got %0d expected 0", bus.partial); end
        checks++; if (bus.win !== 1'b1) begin errors++; $display("FAIL identical_win got %0b expected 1", bus.win); end
    endtask

    task automatic test_async_reset();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        checks++; if (bus.exact !== 3'd0) begin errors++; $display("FAIL async_reset_exact got %0d expected 0", bus.exact); end
        checks++; if (bus.partial !== 3'd0) begin errors++; $display("FAIL async_reset_partial got %0d expected 0", bus.partial); end
        checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL async_reset_win got %0b expected 0", bus.win); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %0b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL async_reset_done got %0b expected 0", bus.done); end
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_patterns();
        int lat;
        // Full permutation
        run_pass(pk(3'd0, 3'd1, 3'd2, 3'd3), pk(3'd3, 3'd2, 3'd1, 3'd0), lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL perm_latency got %0d expected 9", lat); end
        checks++; if (bus.exact !== 3'd0) begin errors++; $display("FAIL perm_exact got %0d expected 0", bus.exact); end
        checks++; if (bus.partial !== 3'd4) begin errors++; $display("FAIL perm_partial got %0d expected 4", bus.partial); end
        checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL perm_win got %0b expected 0", bus.win); end
        // Duplicate colours
        run_pass(pk(3'd1, 3'd1, 3'd2, 3'd3), pk(3'd1, 3'd2, 3'd1, 3'd1), lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL dup_latency got %0d expected 9", lat); end
        checks++; if (bus.exact !== 3'd1) begin errors++; $display("FAIL dup_exact got %0d expected 1", bus.exact); end
        checks++; if (bus.partial !== 3'd2) begin errors++; $display("FAIL dup_partial got %0d expected 2", bus.partial); end
        // No common colours
        run_pass(pk(3'd0, 3'd0, 3'd0, 3'd0), pk(3'd7, 3'd6, 3'd5, 3'd4), lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL none_latency got %0d expected 9", lat); end
        checks++; if (bus.exact !== 3'd0) begin errors++; $display("FAIL none_exact got %0d expected 0", bus.exact); end
        checks++; if (bus.partial !== 3'd0) begin errors++; $display("FAIL none_partial got %0d expected 0", bus.partial); end
    endtask

    task automatic test_ignored_start();
        int dcount;
        bus.secret = pk(3'd6, 3'd2, 3'd2, 3'd4);
        bus.guess  = pk(3'd2, 3'd6, 3'd4, 3'd2);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (2) @(negedge clk);
        bus.start  = 1'b1;
        bus.guess  = pk(3'd6, 3'd2, 3'd2, 3'd4);
        @(negedge clk);
        bus.start  = 1'b0;
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        checks++; if (dcount != 1) begin errors++; $display("FAIL ignored_start_done_count got %0d expected 1", dcount); end
        checks++; if (bus.exact !== 3'd0) begin errors++; $display("FAIL ignored_start_exact got %0d expected 0", bus.exact); end
        checks++; if (bus.partial !== 3'd4) begin errors++; $display("FAIL ignored_start_partial got %0d expected 4", bus.partial); end
        checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL ignored_start_win got %0b expected 0", bus.win); end
    endtask

    task automatic test_abort();
        int dcount;
        int lat;
        bus.secret = pk(3'd1, 3'd2, 3'd3, 3'd4);
        bus.guess  = pk(3'd1, 3'd2, 3'd3, 3'd4);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (4) @(negedge clk);
        #2 Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        checks++; if (dcount != 0) begin errors++; $display("FAIL abort_done_count got %0d expected 0", dcount); end
        checks++; if (bus.partial !== 3'd0) begin errors++; $display("FAIL abort_partial got %0d expected 0", bus.partial); end
        checks++; if (bus.exact !== 3'd0) begin errors++; $display("FAIL abort_exact got %0d expected 0", bus.exact); end
        checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL abort_win got %0b expected 0", bus.win); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b expected 0", bus.busy); end
        run_pass(pk(3'd7, 3'd3, 3'd3, 3'd0), pk(3'd3, 3'd7, 3'd0, 3'd3), lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL after_abort_latency got %0d expected 9", lat); end
        checks++; if (bus.exact !== 3'd0) begin errors++; $display("FAIL after_abort_exact got %0d expected 0", bus.exact); end
        checks++; if (bus.partial !== 3'd4) begin errors++; $display("FAIL after_abort_partial got %0d expected 4", bus.partial); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        bus.secret = pk(3'd3, 3'd1, 3'd4, 3'd5);
        bus.guess  = pk(3'd3, 3'd1, 3'd4, 3'd5);
        bus.start  = 1'b1;
        @(negedge clk);
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_first_latency got %0d expected 9", lat); end
        checks++; if (bus.win !== 1'b1) begin errors++; $display("FAIL b2b_first_win got %0b expected 1", bus.win); end
        bus.secret = pk(3'd1, 3'd1, 3'd2, 3'd3);
        bus.guess  = pk(3'd1, 3'd2, 3'd1, 3'd1);
        gap = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                gap = i;
                break;
            end
        end
        bus.start = 1'b0;
        checks++; if (gap < 10 || gap > 11) begin errors++; $display("FAIL b2b_gap got %0d expected 10..11", gap); end
        checks++; if (bus.exact !== 3'd1) begin errors++; $display("FAIL b2b_second_exact got %0d expected 1", bus.exact); end
        checks++; if (bus.partial !== 3'd2) begin errors++; $display("FAIL b2b_second_partial got %0d expected 2", bus.partial); end
        checks++; if (bus.win !== 1'b0) begin errors++; $display("FAIL b2b_second_win got %0b expected 0", bus.win); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_identical();
        test_async_reset();
        test_patterns();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
